mac_fp32_deconverter: RTL and testbench
=======================================

MAC_FP32_DECONVERTER -- requirements
Module: mac_fp32_deconverter

Interface
REQ-001 SHALL have parameter W_O_EXP, default 6, meaning output exponent width.
REQ-002 SHALL have parameter W_O_INT, default 34, meaning output two's-complement integer width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_ifm_datatype, input, mac_datatype, IFM type (FP16/FP8/I9), sampled with i_data.
REQ-006 SHALL have port i_wfm_datatype, input, mac_datatype, WFM type, sampled with i_data.
REQ-007 SHALL have ports i_valid (input, 1), o_ready (output, 1) and i_data (input, 32), an FP32 input beat.
REQ-008 SHALL have ports o_valid (output, 1), i_ready (input, 1), o_exp (output, W_O_EXP) and o_intdata (output, W_O_INT), the MAC-domain result.

Function
REQ-009 SHALL accept a beat when i_valid&o_ready, deliver it when o_valid&i_ready, and keep o_exp/o_intdata stable while o_valid&!i_ready.
REQ-010 SHALL be a 2-stage pipeline (S0: unpack/exponent select; S1: shift/round/saturate); latency is exactly 2 cycles with no stall.
REQ-011 SHALL advance stage n when stage n is empty or stage n+1 advances; o_ready = !S0_valid | S0_advance (full throughput, no bubble under continuous i_ready).
REQ-012 SHALL decode E=i_data[30:23], M24={1,i_data[22:0]}; E==0 (zero/denormal) gives o_exp=0, o_intdata=0.
REQ-013 SHALL, for FP modes, use bi/bw = 15 (FP16), 7 (FP8), K = -25-bi-bw, and t = clamp(E-133+bi+bw, 0, 2^W_O_EXP-1).
REQ-014 SHALL, for I9 IFM, use t=0 and K=0 (o_intdata is the rounded integer value).
REQ-015 SHALL compute sh = E-150-t-K; the result magnitude is M24<<sh for sh>=0, or M24>>-sh rounded to nearest, ties to even, for sh<0.
REQ-016 SHALL give magnitude 0 for sh<=-25, and saturate to 2^(W_O_INT-1)-1 when the magnitude exceeds it (sh>=10 at default width).
REQ-017 SHALL negate the magnitude when i_data[31]=1; saturation is symmetric, -(2^(W_O_INT-1)-1).
REQ-018 SHALL treat E==255 as saturation: Inf keeps its sign; NaN yields the positive maximum; o_exp=t with E=255.
REQ-019 SHALL output o_exp=t; the value represented is o_intdata*2^(o_exp+K), the inverse of mac_fp32_converter.

Reset
REQ-020 SHALL, while i_rst_n=0, clear all stage valids, so that o_valid=0, o_exp=0 and o_intdata=0.
REQ-021 SHALL drive o_ready=1 in the first cycle after reset release.
REQ-022 SHALL discard in-flight beats when reset asserts mid-operation; no partial result is ever presented.

Configuration
REQ-023 SHALL, with MAC_FP32_DECONV_SAT_FLAG_EN defined, add output o_sat (1, qualified by o_valid, set on REQ-016/REQ-018 saturation) and sticky output o_sat_sticky.
REQ-024 SHALL clear o_sat_sticky only on reset or on input i_sat_clr (1 cycle); a set and a clear in the same cycle leaves it set.
REQ-025 SHALL, without MAC_FP32_DECONV_SAT_FLAG_EN, omit those ports and that logic; datapath behaviour is identical.

Structure
REQ-026 SHALL import mac_datatype and the FP16/FP8 bias constants from mac_pkg; new constants (FP32 bias 127, FP32 mantissa width 23) belong in mac_pkg.
REQ-027 SHALL implement S1 rounding in a sub-module mac_rne_shifter (magnitude, signed shift → rounded magnitude and overflow).

Verification
REQ-028 SHALL check FP16×FP16, 0x3F800000 -> o_exp=24, o_intdata=0x0_8000_0000, 2 cycles after acceptance.
REQ-029 SHALL check I9, 0x40200000 (2.5) -> 2, and 0xC0600000 (-3.5) -> -4 (ties to even).
REQ-030 SHALL check I9, 0x5368D4A5 (~1e12) -> 0x1_FFFF_FFFF, and 0xFF800000 -> -(2^33-1), with o_sat=1 when the macro is defined.
REQ-031 SHALL check 0x00000001 (denormal) and 0x80000000 -> o_exp=0, o_intdata=0.
REQ-032 SHALL check 8 back-to-back beats with i_ready toggling 1010...: no loss, no duplication, order preserved, o_ready low only when both stages are full and the output is stalled.
REQ-033 SHALL check that i_rst_n pulsed low with 2 beats in flight -> o_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC datatype encoding and floating-point format constants.
package mac_pkg;

  typedef enum logic [1:0] {
    MAC_DT_FP16 = 2'd0,
    MAC_DT_FP8  = 2'd1,
    MAC_DT_I9   = 2'd2
  } mac_datatype;

  localparam int unsigned FP16_BIAS    = 15;
  localparam int unsigned FP8_BIAS     = 7;
  localparam int unsigned FP32_BIAS    = 127;
  localparam int unsigned FP32_MANT_W  = 23;
  localparam int unsigned FP32_EXP_W   = 8;
  localparam int unsigned FP32_SH_BIAS = FP32_BIAS + FP32_MANT_W;

  // Exponent bias of a MAC operand type; integer operands carry no bias.
  function automatic int unsigned mac_fp_bias(input mac_datatype dt);
    case (dt)
      MAC_DT_FP16: return FP16_BIAS;
      MAC_DT_FP8:  return FP8_BIAS;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/mac_rne_shifter.sv
// Shifts an unsigned magnitude by a signed amount; right shifts round to
// nearest, ties to even. o_ovf flags a result that does not fit W_OUT bits.
module mac_rne_shifter #(
  parameter int unsigned W_IN  = 24,
  parameter int unsigned W_OUT = 33,
  parameter int unsigned W_SH  = 10
) (
  input  logic [W_IN-1:0]        i_mag,
  input  logic signed [W_SH-1:0] i_sh,
  output logic [W_OUT-1:0]       o_mag,
  output logic                   o_ovf
);

  localparam int unsigned W_WIDE = W_IN + W_OUT + 1;

  logic [W_WIDE-1:0] wide;
  logic [W_IN-1:0]   q;
  logic [W_IN-1:0]   rem_mask;
  logic [W_SH-1:0]   n;
  logic              guard;
  logic              sticky;

  always_comb begin
    wide     = '0;
    q        = '0;
    rem_mask = '0;
    n        = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (!i_sh[W_SH-1]) begin
      if ($unsigned(i_sh) >= W_SH'(W_OUT)) begin
        wide[W_WIDE-1] = |i_mag;
      end else begin
        wide = W_WIDE'(i_mag) << $unsigned(i_sh);
      end
    end else begin
      n = -$unsigned(i_sh);
      // Shifting by more than W_IN leaves less than half an LSB: rounds to zero.
      if (n <= W_SH'(W_IN)) begin
        q        = i_mag >> n;
        guard    = |(i_mag & (W_IN'(1) << (n - W_SH'(1))));
        rem_mask = (W_IN'(1) << (n - W_SH'(1))) - W_IN'(1);
        sticky   = |(i_mag & rem_mask);
        wide     = W_WIDE'(q) + W_WIDE'(guard & (sticky | q[0]));
      end
    end
    o_ovf = |wide[W_WIDE-1:W_OUT];
    o_mag = wide[W_OUT-1:0];
  end

endmodule

// File: rtl/mac_fp32_deconverter.sv
// FP32 -> MAC-domain (exponent, two's-complement integer) converter, 2-stage
// pipeline. Optional saturation flags under MAC_FP32_DECONV_SAT_FLAG_EN.
module mac_fp32_deconverter
  import mac_pkg::*;
#(
  parameter int unsigned W_O_EXP = 6,
  parameter int unsigned W_O_INT = 34
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  mac_datatype        i_ifm_datatype,
  input  mac_datatype        i_wfm_datatype,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [31:0]        i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [W_O_EXP-1:0] o_exp,
`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
  output logic               o_sat,
  output logic               o_sat_sticky,
  input  logic               i_sat_clr,
`endif
  output logic [W_O_INT-1:0] o_intdata
);

  localparam int unsigned W_MAG    = W_O_INT - 1;
  localparam int unsigned W_SH     = 10;
  localparam int unsigned W_M      = FP32_MANT_W + 1;
  localparam int          T_MAX    = int'((1 << W_O_EXP) - 1);
  localparam int          T_BIAS   = 133;
  localparam int          K_OFFSET = 25;

  logic                   s0_valid_q, s0_valid_d;
  logic                   s0_sign_q, s0_sign_d;
  logic                   s0_zero_q, s0_zero_d;
  logic                   s0_special_q, s0_special_d;
  logic                   s0_nan_q, s0_nan_d;
  logic [W_M-1:0]         s0_mag_q, s0_mag_d;
  logic signed [W_SH-1:0] s0_sh_q, s0_sh_d;
  logic [W_O_EXP-1:0]     s0_exp_q, s0_exp_d;

  logic                   out_valid_q, out_valid_d;
  logic [W_O_EXP-1:0]     out_exp_q, out_exp_d;
  logic [W_O_INT-1:0]     out_int_q, out_int_d;

  logic                   s0_adv, s1_adv;
  logic [W_MAG-1:0]       rne_mag;
  logic                   rne_ovf;
  logic                   s1_sat;
  logic [W_MAG-1:0]       s1_mag;
  logic [W_O_INT-1:0]     s1_int;
  logic [W_O_EXP-1:0]     s1_exp;
  logic [FP32_EXP_W-1:0]  in_e;
  int                     e, bsum, t, k, sh;

  assign s1_adv  = !out_valid_q || i_ready;
  assign s0_adv  = !s0_valid_q || s1_adv;
  assign o_ready = s0_adv;
  assign in_e    = i_data[30:23];

  // S0: unpack and choose the output exponent and the shift amount.
  always_comb begin
    e    = int'(in_e);
    bsum = int'(mac_fp_bias(i_ifm_datatype)) + int'(mac_fp_bias(i_wfm_datatype));
    t    = 0;
    k    = 0;
    if (i_ifm_datatype != MAC_DT_I9) begin
      k = -K_OFFSET - bsum;
      t = e - T_BIAS + bsum;
      if (t < 0) t = 0;
      else if (t > T_MAX) t = T_MAX;
    end
    sh = e - int'(FP32_SH_BIAS) - t - k;

    s0_valid_d   = s0_valid_q;
    s0_sign_d    = s0_sign_q;
    s0_zero_d    = s0_zero_q;
    s0_special_d = s0_special_q;
    s0_nan_d     = s0_nan_q;
    s0_mag_d     = s0_mag_q;
    s0_sh_d      = s0_sh_q;
    s0_exp_d     = s0_exp_q;
    if (s0_adv) begin
      s0_valid_d = i_valid;
      if (i_valid) begin
        s0_sign_d    = i_data[31];
        s0_zero_d    = (in_e == '0);
        s0_special_d = (in_e == '1);
        s0_nan_d     = (in_e == '1) && (i_data[22:0] != '0);
        s0_mag_d     = {1'b1, i_data[22:0]};
        s0_sh_d      = W_SH'(sh);
        s0_exp_d     = W_O_EXP'(t);
      end
    end
  end

  mac_rne_shifter #(
    .W_IN (W_M),
    .W_OUT(W_MAG),
    .W_SH (W_SH)
  ) u_rne (
    .i_mag(s0_mag_q),
    .i_sh (s0_sh_q),
    .o_mag(rne_mag),
    .o_ovf(rne_ovf)
  );

  // S1: saturate, apply sign; NaN saturates positive, zero/denormal is all-zero.
  always_comb begin
    s1_sat = !s0_zero_q && (s0_special_q || rne_ovf);
    s1_mag = s1_sat ? {W_MAG{1'b1}} : rne_mag;
    s1_int = (s0_sign_q && !s0_nan_q) ? -{1'b0, s1_mag} : {1'b0, s1_mag};
    s1_exp = s0_exp_q;
    if (s0_zero_q) begin
      s1_int = '0;
      s1_exp = '0;
    end

    out_valid_d = out_valid_q;
    out_exp_d   = out_exp_q;
    out_int_d   = out_int_q;
    if (s1_adv) begin
      out_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        out_exp_d = s1_exp;
        out_int_d = s1_int;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_valid_q   <= 1'b0;
      s0_sign_q    <= 1'b0;
      s0_zero_q    <= 1'b0;
      s0_special_q <= 1'b0;
      s0_nan_q     <= 1'b0;
      s0_mag_q     <= '0;
      s0_sh_q      <= '0;
      s0_exp_q     <= '0;
      out_valid_q  <= 1'b0;
      out_exp_q    <= '0;
      out_int_q    <= '0;
    end else begin
      s0_valid_q   <= s0_valid_d;
      s0_sign_q    <= s0_sign_d;
      s0_zero_q    <= s0_zero_d;
      s0_special_q <= s0_special_d;
      s0_nan_q     <= s0_nan_d;
      s0_mag_q     <= s0_mag_d;
      s0_sh_q      <= s0_sh_d;
      s0_exp_q     <= s0_exp_d;
      out_valid_q  <= out_valid_d;
      out_exp_q    <= out_exp_d;
      out_int_q    <= out_int_d;
    end
  end

  assign o_valid   = out_valid_q;
  assign o_exp     = out_exp_q;
  assign o_intdata = out_int_q;

`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
  logic sat_q, sat_d;
  logic sat_sticky_q, sat_sticky_d;

  // Sticky set has priority over a coincident clear.
  always_comb begin
    sat_d        = sat_q;
    sat_sticky_d = sat_sticky_q;
    if (s1_adv && s0_valid_q) sat_d = s1_sat;
    if (i_sat_clr) sat_sticky_d = 1'b0;
    if (s1_adv && s0_valid_q && s1_sat) sat_sticky_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_q        <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      sat_q        <= sat_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign o_sat        = sat_q;
  assign o_sat_sticky = sat_sticky_q;
`endif

endmodule

// File: tb/tb_mac_fp32_deconverter.sv
// Self-checking bench for mac_fp32_deconverter: directed corner cases, backpressure,
// mid-flight reset and randomized beats against a real-arithmetic reference model.
module tb_mac_fp32_deconverter;
  import mac_pkg::*;

  localparam int unsigned W_O_EXP = 6;
  localparam int unsigned W_O_INT = 34;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  mac_datatype        i_ifm_datatype = MAC_DT_FP16;
  mac_datatype        i_wfm_datatype = MAC_DT_FP16;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [31:0]        i_data = '0;
  logic               o_valid;
  logic               i_ready = 1'b0;
  logic [W_O_EXP-1:0] o_exp;
  logic [W_O_INT-1:0] o_intdata;
`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
  logic               o_sat;
  logic               o_sat_sticky;
  logic               i_sat_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  mac_fp32_deconverter #(.W_O_EXP(W_O_EXP), .W_O_INT(W_O_INT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ifm_datatype(i_ifm_datatype),
    .i_wfm_datatype(i_wfm_datatype),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_exp         (o_exp),
`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
    .o_sat         (o_sat),
    .o_sat_sticky  (o_sat_sticky),
    .i_sat_clr     (i_sat_clr),
`endif
    .o_intdata     (o_intdata)
  );

  typedef struct {
    logic [W_O_EXP-1:0] ex;
    logic [W_O_INT-1:0] iv;
    logic               sat;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int bias_of(input mac_datatype dt);
    if (dt == MAC_DT_FP16) return 15;
    if (dt == MAC_DT_FP8) return 7;
    return 0;
  endfunction

  // Value-level model: exact real scaling, then round-half-even and saturate.
  function automatic exp_t model(input logic [31:0] d, input mac_datatype ifm, input mac_datatype wfm);
    exp_t   r;
    int     e, bsum, t, k, sh;
    longint maxv, mag;
    real    v, f, fr;
    bit     neg, sat;
    r.ex  = '0;
    r.iv  = '0;
    r.sat = 1'b0;
    maxv  = (longint'(1) << (W_O_INT - 1)) - 1;
    e     = int'(d[30:23]);
    if (e == 0) return r;
    bsum = bias_of(ifm) + bias_of(wfm);
    if (ifm == MAC_DT_I9) begin
      t = 0;
      k = 0;
    end else begin
      k = -25 - bsum;
      t = e - 133 + bsum;
      if (t < 0) t = 0;
      if (t > 63) t = 63;
    end
    sh  = e - 150 - t - k;
    neg = d[31];
    sat = 1'b0;
    mag = 0;
    if (e == 255) begin
      sat = 1'b1;
      mag = maxv;
      if (d[22:0] != 0) neg = 1'b0;
    end else begin
      v = real'(longint'({1'b1, d[22:0]})) * (2.0 ** real'(sh));
      if (v >= 2.0 ** 40) begin
        sat = 1'b1;
        mag = maxv;
      end else begin
        f   = $floor(v);
        fr  = v - f;
        mag = longint'(f);
        if (fr > 0.5 || (fr == 0.5 && mag[0])) mag++;
        if (mag > maxv) begin
          sat = 1'b1;
          mag = maxv;
        end
      end
    end
    r.ex  = W_O_EXP'(t);
    r.iv  = neg ? W_O_INT'(-mag) : W_O_INT'(mag);
    r.sat = sat;
    return r;
  endfunction

  // One cycle: sample just after the falling edge, score the handshakes, advance.
  task automatic tick(output bit acc, output bit del);
    exp_t e;
    #1;
    acc = 1'b0;
    del = 1'b0;
    if (rst_n) begin
      if (o_valid) begin
        if (sbq.size() == 0) chk("o_valid_idle", 64'(o_valid), 64'd0);
        else begin
          e = sbq[0];
          chk("o_exp", 64'(o_exp), 64'(e.ex));
          chk("o_intdata", 64'(o_intdata), 64'(e.iv));
`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
          chk("o_sat", 64'(o_sat), 64'(e.sat));
`endif
        end
      end
      acc = i_valid && o_ready;
      del = o_valid && i_ready;
      if (acc) sbq.push_back(model(i_data, i_ifm_datatype, i_wfm_datatype));
      if (del && sbq.size() > 0) void'(sbq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] d, input mac_datatype ifm,
                          input mac_datatype wfm, input logic [5:0] ee, input logic [33:0] ei,
                          input logic esat);
    bit a, b;
    i_ready        = 1'b1;
    i_ifm_datatype = ifm;
    i_wfm_datatype = wfm;
    i_valid        = 1'b1;
    i_data         = d;
    tick(a, b);
    chk({tag, "_accept"}, 64'(a), 64'd1);
    i_valid = 1'b0;
    i_data  = $urandom;
    #1 chk({tag, "_lat1_valid"}, 64'(o_valid), 64'd0);
    tick(a, b);
    #1;
    chk({tag, "_lat2_valid"}, 64'(o_valid), 64'd1);
    chk({tag, "_exp"}, 64'(o_exp), 64'(ee));
    chk({tag, "_int"}, 64'(o_intdata), 64'(ei));
`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
    chk({tag, "_sat"}, 64'(o_sat), 64'(esat));
`else
    if (esat === 1'bx) $display("note: %s", tag);
`endif
    tick(a, b);
  endtask

  function automatic logic [31:0] rand_fp(input bit i9);
    logic [7:0]  e;
    logic [22:0] m;
    int          sel;
    sel = int'($urandom % 10);
    if (sel == 0) e = 8'd0;
    else if (sel == 1) e = 8'd255;
    else if (i9) e = 8'($urandom_range(100, 170));
    else e = 8'($urandom_range(60, 200));
    m = 23'($urandom);
    if ($urandom % 3 == 0) m = m & ~((23'd1 << $urandom_range(1, 22)) - 23'd1);
    return {1'($urandom), e, m};
  endfunction

  task automatic rand_types();
    int s;
    s = int'($urandom % 3);
    i_ifm_datatype = (s == 0) ? MAC_DT_FP16 : (s == 1) ? MAC_DT_FP8 : MAC_DT_I9;
    i_wfm_datatype = ($urandom % 2 == 0) ? MAC_DT_FP16 : MAC_DT_FP8;
  endtask

  initial begin
    bit a, b;
    int sent, got;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_exp", 64'(o_exp), 64'd0);
    chk("rst_o_intdata", 64'(o_intdata), 64'd0);
    rst_n = 1'b1;
    #1 chk("rst_o_ready", 64'(o_ready), 64'd1);
    @(negedge clk);

    // Directed corner cases
    directed("fp16_one", 32'h3F80_0000, MAC_DT_FP16, MAC_DT_FP16, 6'd24, 34'h0_8000_0000, 1'b0);
    directed("i9_2p5", 32'h4020_0000, MAC_DT_I9, MAC_DT_I9, 6'd0, 34'd2, 1'b0);
    directed("i9_m3p5", 32'hC060_0000, MAC_DT_I9, MAC_DT_I9, 6'd0, 34'h3_FFFF_FFFC, 1'b0);
    directed("i9_big", 32'h5368_D4A5, MAC_DT_I9, MAC_DT_I9, 6'd0, 34'h1_FFFF_FFFF, 1'b1);
    directed("i9_ninf", 32'hFF80_0000, MAC_DT_I9, MAC_DT_I9, 6'd0, 34'h2_0000_0001, 1'b1);
`ifdef MAC_FP32_DECONV_SAT_FLAG_EN
    #1 chk("sticky_set", 64'(o_sat_sticky), 64'd1);
    i_sat_clr = 1'b1;
    @(negedge clk);
    i_sat_clr = 1'b0;
    #1 chk("sticky_clr", 64'(o_sat_sticky), 64'd0);
    @(negedge clk);
`endif
    directed("denorm", 32'h0000_0001, MAC_DT_FP16, MAC_DT_FP16, 6'd0, 34'd0, 1'b0);
    directed("neg_zero", 32'h8000_0000, MAC_DT_FP8, MAC_DT_FP16, 6'd0, 34'd0, 1'b0);

    // 8 back-to-back beats with output ready toggling 1010...
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 64 && (sent < 8 || sbq.size() > 0); cyc++) begin
      rand_types();
      i_valid = (sent < 8);
      i_data  = rand_fp(i_ifm_datatype == MAC_DT_I9);
      i_ready = (cyc % 2 == 0);
      #1 chk("bp_o_ready", 64'(o_ready), 64'(!(sbq.size() == 2 && !i_ready)));
      tick(a, b);
      sent += int'(a);
      got  += int'(b);
    end
    i_valid = 1'b0;
    chk("bp_delivered", 64'(got), 64'd8);
    chk("bp_pending", 64'(sbq.size()), 64'd0);

    // Reset with two beats in flight
    i_ready = 1'b0;
    i_ifm_datatype = MAC_DT_FP16;
    i_wfm_datatype = MAC_DT_FP16;
    i_valid = 1'b1;
    i_data  = 32'h3F80_0000;
    tick(a, b);
    i_data  = 32'h4000_0000;
    tick(a, b);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", 64'(o_valid), 64'd0);
    chk("midrst_o_intdata", 64'(o_intdata), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("postrst_o_valid", 64'(o_valid), 64'd0);
      tick(a, b);
    end

    // Randomized traffic with random backpressure
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 4000 && (sent < 400 || sbq.size() > 0); cyc++) begin
      rand_types();
      i_valid = (sent < 400) && ($urandom % 4 != 0);
      i_data  = rand_fp(i_ifm_datatype == MAC_DT_I9);
      i_ready = ($urandom % 4 != 0);
      tick(a, b);
      sent += int'(a);
      got  += int'(b);
    end
    i_valid = 1'b0;
    chk("rand_delivered", 64'(got), 64'd400);
    chk("rand_pending", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
